// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// Rank 0 captures the conditioned operands; rank k+1 holds the beat after
// slice k has been added, so rank STAGES is the output register and the
// latency from acceptance to out_valid is STAGES cycles.
module cla_pipe_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned SLICE = WIDTH / STAGES;

  // One slice: 4-bit lookahead groups, rippling between groups.
  // Returns {carry out, carry into slice MSB, sum}.
  function automatic logic [SLICE+1:0] slice_add(
    input logic [SLICE-1:0] a,
    input logic [SLICE-1:0] b,
    input logic             cin
  );
    logic [SLICE-1:0] g, p, s;
    logic [SLICE:0]   c;
    int unsigned      j;
    g    = a & b;
    p    = a | b;
    c    = '0;
    c[0] = cin;
    for (int unsigned grp = 0; grp < SLICE / 4; grp++) begin
      j = grp * 4;
      c[j+1] = g[j] | (p[j] & c[j]);
      c[j+2] = g[j+1] | (p[j+1] & g[j]) | (p[j+1] & p[j] & c[j]);
      c[j+3] = g[j+2] | (p[j+2] & g[j+1]) | (p[j+2] & p[j+1] & g[j])
             | (p[j+2] & p[j+1] & p[j] & c[j]);
      c[j+4] = g[j+3] | (p[j+3] & g[j+2]) | (p[j+3] & p[j+2] & g[j+1])
             | (p[j+3] & p[j+2] & p[j+1] & g[j])
             | (p[j+3] & p[j+2] & p[j+1] & p[j] & c[j]);
    end
    s = a ^ b ^ c[SLICE-1:0];
    return {c[SLICE], c[SLICE-1], s};
  endfunction

  logic [STAGES:0]   v_q;
  logic [STAGES:0]   c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES+1];
  logic [WIDTH-1:0]  r_nxt [STAGES];
  logic [STAGES-1:0] c_nxt;
  logic              cmsb_last;
  logic [SLICE+1:0]  res;
  logic              ovf_q, zero_q, neg_q;
  logic              adv;

  assign adv       = !v_q[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES];
  assign dout      = r_q[STAGES];
  assign carry_out = c_q[STAGES];
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

  // Each stage adds its own slice and merges it into the skewed result word.
  always_comb begin
    cmsb_last = 1'b0;
    res       = '0;
    c_nxt     = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      res = slice_add(a_q[k][k*SLICE +: SLICE], b_q[k][k*SLICE +: SLICE], c_q[k]);
      r_nxt[k] = r_q[k];
      r_nxt[k][k*SLICE +: SLICE] = res[SLICE-1:0];
      c_nxt[k] = res[SLICE+1];
      if (k == STAGES - 1) cmsb_last = res[SLICE];
    end
  end

  // Pipeline ranks: shift everything together when the output can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int unsigned k = 0; k <= STAGES; k++) r_q[k] <= '0;
    end else if (adv) begin
      v_q    <= {v_q[STAGES-1:0], in_valid};
      a_q[0] <= din1;
      b_q[0] <= din2 ^ {WIDTH{sub}};
      c_q[0] <= carry_in ^ sub;
      // A freshly accepted beat has no result bits yet.
      r_q[0] <= '0;
      for (int unsigned k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_q[k+1] <= r_nxt[k];
        c_q[k+1] <= c_nxt[k];
      end
      ovf_q  <= cmsb_last ^ c_nxt[STAGES-1];
      zero_q <= ~|r_nxt[STAGES-1];
      neg_q  <= r_nxt[STAGES-1][WIDTH-1];
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed 16-bit/2-stage scenarios plus a
// randomised 32-bit/4-stage run against an arithmetic reference model.
module tb_cla_pipe_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 16-bit, 2-stage instance
  logic        a_iv, a_ir, a_ov, a_or, a_cin, a_sub, a_co, a_ovf, a_z, a_n;
  logic [15:0] a_d1, a_d2, a_do;
  // 32-bit, 4-stage instance
  logic        b_iv, b_ir, b_ov, b_or, b_cin, b_sub, b_co, b_ovf, b_z, b_n;
  logic [31:0] b_d1, b_d2, b_do;

  cla_pipe_addsub #(.WIDTH(16), .STAGES(2)) u16 (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir),
    .din1(a_d1), .din2(a_d2), .carry_in(a_cin), .sub(a_sub),
    .out_valid(a_ov), .out_ready(a_or), .dout(a_do), .carry_out(a_co),
    .overflow(a_ovf), .zero(a_z), .negative(a_n)
  );

  cla_pipe_addsub #(.WIDTH(32), .STAGES(4)) u32 (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir),
    .din1(b_d1), .din2(b_d2), .carry_in(b_cin), .sub(b_sub),
    .out_valid(b_ov), .out_ready(b_or), .dout(b_do), .carry_out(b_co),
    .overflow(b_ovf), .zero(b_z), .negative(b_n)
  );

  typedef struct packed {
    logic [15:0] a, b;
    logic        s, c;
    logic [15:0] d;
    logic        co, ov, z, n;
  } vec16_t;

  typedef struct {
    logic [31:0] d;
    logic        co, ov;
  } exp32_t;

  // Reference: exact integer arithmetic, no knowledge of the adder structure.
  function automatic exp32_t model32(input logic [31:0] a, input logic [31:0] b,
                                     input logic s, input logic c);
    exp32_t e;
    longint u, sr;
    if (!s) begin
      u  = longint'(a) + longint'(b) + longint'(c);
      sr = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
      e.co = (u >= 64'sd4294967296);
    end else begin
      u  = longint'(a) - longint'(b) - longint'(c);
      sr = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
      e.co = (u >= 0);
    end
    e.d  = u[31:0];
    e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return e;
  endfunction

  task automatic drive16(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic s, input logic c, input logic ordy);
    a_iv = v; a_d1 = x; a_d2 = y; a_sub = s; a_cin = c; a_or = ordy;
  endtask

  task automatic idle32();
    b_iv = 1'b0; b_d1 = '0; b_d2 = '0; b_sub = 1'b0; b_cin = 1'b0; b_or = 1'b1;
  endtask

  task automatic flush16();
    repeat (4) begin
      @(negedge clk);
      drive16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive16(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    idle32();
    b_iv = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({a_ov, a_co, a_ovf, a_z, a_n, a_do} !== '0) begin
      errors++;
      $display("FAIL reset16_outputs: got ov=%b co=%b ovf=%b z=%b n=%b d=%h, want all 0",
               a_ov, a_co, a_ovf, a_z, a_n, a_do);
    end
    checks++;
    if ({b_ov, b_co, b_ovf, b_z, b_n, b_do} !== '0) begin
      errors++;
      $display("FAIL reset32_outputs: got ov=%b co=%b ovf=%b z=%b n=%b d=%h, want all 0",
               b_ov, b_co, b_ovf, b_z, b_n, b_do);
    end
    rst = 1'b0;
    drive16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle32();
    #1;
    checks++;
    if (a_ir !== 1'b1 || b_ir !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b/%b, want 1/1", a_ir, b_ir);
    end
  endtask

  task automatic test_directed();
    vec16_t v[7];
    v[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    v[1] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    v[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    v[3] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
    v[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    v[5] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    v[6] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive16(1'b1, v[i].a, v[i].b, v[i].s, v[i].c, 1'b1);
      for (int t = 1; t <= 3; t++) begin
        @(negedge clk);
        drive16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (a_ov !== (t == 3)) begin
          errors++;
          $display("FAIL directed%0d_latency: cycle %0d out_valid=%b, want %b", i, t, a_ov, t == 3);
        end
      end
      checks++;
      if ({a_do, a_co, a_ovf, a_z, a_n} !== {v[i].d, v[i].co, v[i].ov, v[i].z, v[i].n}) begin
        errors++;
        $display("FAIL directed%0d_result: got d=%h co=%b ovf=%b z=%b n=%b, want d=%h co=%b ovf=%b z=%b n=%b",
                 i, a_do, a_co, a_ovf, a_z, a_n, v[i].d, v[i].co, v[i].ov, v[i].z, v[i].n);
      end
    end
    flush16();
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (t < 8) drive16(1'b1, 16'(t), 16'(2 * t), 1'b0, 1'b0, 1'b1);
      else       drive16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (a_ir !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready: t=%0d got %b, want 1", t, a_ir);
      end
      checks++;
      if (a_ov !== (t >= 3 && t <= 10)) begin
        errors++;
        $display("FAIL b2b_out_valid: t=%0d got %b, want %b", t, a_ov, t >= 3 && t <= 10);
      end else if (a_ov && a_do !== 16'(3 * (t - 3))) begin
        errors++;
        $display("FAIL b2b_dout: t=%0d got %h, want %h", t, a_do, 16'(3 * (t - 3)));
      end
    end
    flush16();
  endtask

  task automatic test_stall();
    int q[$];
    int sent = 1;
    int got  = 0;
    logic ordy;
    for (int t = 0; t < 40 && got < 12; t++) begin
      @(negedge clk);
      ordy = !(t >= 5 && t < 10);
      drive16(sent <= 12, 16'(sent), 16'(2 * sent), 1'b0, 1'b0, ordy);
      #1;
      checks++;
      if ((ordy && a_ir !== 1'b1) || (!ordy && a_ov && a_ir !== 1'b0)) begin
        errors++;
        $display("FAIL stall_in_ready: t=%0d got %b, out_ready=%b out_valid=%b", t, a_ir, ordy, a_ov);
      end
      if (a_ov) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stall_extra_beat: t=%0d got d=%h, want no result", t, a_do);
        end else if (a_do !== 16'(q[0])) begin
          errors++;
          $display("FAIL stall_dout: t=%0d got %h, want %h", t, a_do, 16'(q[0]));
        end
        if (ordy && q.size() != 0) begin
          void'(q.pop_front());
          got++;
        end
      end
      if (a_iv && a_ir) begin
        q.push_back(3 * sent);
        sent++;
      end
    end
    checks++;
    if (got != 12 || q.size() != 0) begin
      errors++;
      $display("FAIL stall_count: got %0d results with %0d pending, want 12 and 0", got, q.size());
    end
    flush16();
  endtask

  task automatic test_midreset();
    @(negedge clk); drive16(1'b1, 16'd10, 16'd20, 1'b0, 1'b0, 1'b1);
    @(negedge clk); drive16(1'b1, 16'd30, 16'd40, 1'b0, 1'b0, 1'b1);
    @(negedge clk); rst = 1'b1; drive16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); rst = 1'b0; drive16(1'b1, 16'd100, 16'd23, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (a_ov !== 1'b0 || a_ir !== 1'b1) begin
      errors++;
      $display("FAIL midreset_after: got out_valid=%b in_ready=%b, want 0/1", a_ov, a_ir);
    end
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      drive16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (a_ov !== (t == 3)) begin
        errors++;
        $display("FAIL midreset_valid: t=%0d got %b, want %b", t, a_ov, t == 3);
      end else if (a_ov && a_do !== 16'd123) begin
        errors++;
        $display("FAIL midreset_dout: got %h, want %h", a_do, 16'd123);
      end
    end
  endtask

  task automatic test_random();
    exp32_t q[$];
    exp32_t e;
    int sent = 0;
    int done = 0;
    int cyc  = 0;
    while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      b_iv  = (sent < 10000) && ($urandom_range(3) != 0);
      b_or  = ($urandom_range(3) != 0);
      b_d1  = $urandom;
      b_d2  = $urandom;
      b_sub = $urandom_range(1);
      b_cin = $urandom_range(1);
      #1;
      if (b_ov && b_or) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_beat: cycle %0d got d=%h, want no result", cyc, b_do);
        end else begin
          e = q.pop_front();
          if ({b_do, b_co, b_ovf, b_z, b_n} !== {e.d, e.co, e.ov, e.d == 32'd0, e.d[31]}) begin
            errors++;
            $display("FAIL rand_result: beat %0d got d=%h co=%b ovf=%b z=%b n=%b, want d=%h co=%b ovf=%b",
                     done, b_do, b_co, b_ovf, b_z, b_n, e.d, e.co, e.ov);
          end
          done++;
        end
      end
      if (b_iv && b_ir) begin
        q.push_back(model32(b_d1, b_d2, b_sub, b_cin));
        sent++;
      end
    end
    checks++;
    if (done != 10000) begin
      errors++;
      $display("FAIL rand_count: got %0d results in %0d cycles, want 10000", done, cyc);
    end
    idle32();
  endtask

  initial begin
    rst = 1'b1;
    drive16(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle32();
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Successor to the 4-bit combinational CLA: the datapath is built from 4-bit lookahead groups, split across STAGES register stages, with add/sub mode, status flags and a valid/ready handshake.
- Sits in the execute stage as the ALU add/sub path, and in multi-precision arithmetic through carry chaining.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4*STAGES.
- STAGES, 2, number of pipeline register stages (1..8); equals the latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- din1  input  WIDTH  operand A.
- din2  input  WIDTH  operand B.
- carry_in  input  1  carry/borrow-chain input.
- sub  input  1  0 = A+B+carry_in; 1 = A-B-carry_in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- dout  output  WIDTH  sum/difference.
- carry_out  output  1  raw carry out of the MSB.
- overflow  output  1  signed overflow.
- zero  output  1  dout == 0.
- negative  output  1  dout[WIDTH-1].

Behaviour:
- Reset (rst=1 at a clk edge):
  - all stage valid bits, out_valid, dout, carry_out, overflow, zero and negative clear to 0;
  - any beats in flight are discarded;
  - in_ready=1 during the cycle after reset.
- Operand conditioning at acceptance:
  - b = din2 XOR {WIDTH{sub}};
  - effective cin = carry_in XOR sub.
  - Result: sub=1, carry_in=0 gives A-B; sub=1, carry_in=1 gives A-B-1.
  - carry_out is the raw adder carry. In sub mode, 1 means no borrow. It is not inverted.
- Slicing:
  - SLICE = WIDTH/STAGES bits per stage.
  - Stage k (0-based) computes bits [k*SLICE +: SLICE].
  - Each slice is built from 4-bit groups: generate = a&b, propagate = a|b, full lookahead inside a group, ripple between groups within the slice.
  - The carry out of stage k is registered and feeds stage k+1.
  - Operand bits not yet consumed, and result bits already produced, travel alongside in skew registers, so each beat's output is fully aligned.
- Flags at the last stage:
  - overflow = carry into bit WIDTH-1 XOR carry_out;
  - zero = ~|dout;
  - negative = dout[WIDTH-1].
- Handshake and advance:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - adv = !out_valid || out_ready.
  - in_ready = adv. It is combinational from out_ready, with no other combinational input-to-output paths.
  - When adv=1, every stage shifts one step. Stage 0 loads the accepted beat, or a bubble (valid=0) if none is accepted.
  - When adv=0, every stage register holds its value. dout and flags are stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - A beat accepted at edge N appears with out_valid=1 after edge N+STAGES, given adv=1 throughout.
  - Throughput is 1 beat/cycle with no bubbles while out_ready=1.
  - Bubbles propagate as valid=0 and never produce out_valid.
- Ordering: strict FIFO order; no reordering.
- Simultaneous events:
  - Acceptance and consumption in the same cycle are legal and lossless.
  - rst has priority over all other events.
- Output register contents when out_valid=0: dout and flags keep the last shifted values. These are don't-care; the bench checks them only when out_valid=1.

Test Plan:
- WIDTH=16, STAGES=2; din1=0x7FFF, din2=0x0001, sub=0, cin=0 -> 2 cycles later: dout=0x8000, overflow=1, negative=1, carry_out=0, zero=0.
- din1=0x0005, din2=0x0005, sub=1, cin=0 -> dout=0x0000, zero=1, carry_out=1 (no borrow), overflow=0.
- din1=0xFFFF, din2=0x0001, sub=0 -> dout=0x0000, carry_out=1, zero=1. The carry must cross the stage boundary at bit 8.
- Stream 8 back-to-back beats (i, 2i) with out_ready=1 -> 8 consecutive out_valid cycles, dout=3i in order, first result exactly 2 cycles after the first acceptance.
- Hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, dout stable, no beat lost or duplicated after out_ready returns to 1.
- Assert rst for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle, no stale result ever emitted; a new beat afterwards completes with correct latency.
- Randomised 10k beats at WIDTH=32, STAGES=4, random out_ready -> dout, carry_out and overflow match the reference model: (A ± B ± cin) mod 2^32.
